wlord_driver: RTL and testbench

WLORD_DRIVER -- requirements
Module: wlord_driver

---
 rtl/wlord_driver_if.sv | 28 ++
 rtl/wlord_driver.sv | 174 +++++++++++++++++
 tb/tb_wlord_driver.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/wlord_driver_if.sv
// Bus between a measurement controller and the word-line enable driver:
// sequence request/configuration inward, enable lines and status outward.
interface wlord_driver_if #(
  parameter int N     = 32,
  parameter int WIDTH = 12,
  parameter int IW    = $clog2(N)
);
  logic             start;
  logic             abort;
  logic             mode;
  logic [N-1:0]     mask;
  logic [WIDTH-1:0] win_len;
  logic [N-1:0]     wlord;
  logic [IW-1:0]    cur_line;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output start, abort, mode, mask, win_len,
    input  wlord, cur_line, busy, done, aborted
  );

  modport slave (
    input  start, abort, mode, mask, win_len,
    output wlord, cur_line, busy, done, aborted
  );
endinterface

// File: rtl/wlord_driver.sv
// Word-line enable sequencer: drives masked lines for a timed window, either all
// together (parallel) or one at a time in ascending order (walk).
module wlord_driver #(
  parameter int N     = 32,
  parameter int WIDTH = 12,
  parameter int IW    = $clog2(N)
) (
  input logic           clk,
  input logic           rst,
  wlord_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Returns {found, index} of the lowest set bit of m at or above position lo.
  function automatic logic [IW:0] next_set(input logic [N-1:0] m, input int lo);
    logic [IW:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i] && (i >= lo)) begin
        r = {1'b1, IW'(i)};
      end
    end
    return r;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_e           state_q, state_d;
  logic [N-1:0]     mask_q, mask_d;
  logic [WIDTH-1:0] win_q, win_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    line_q, line_d;
  logic [N-1:0]     wlord_q, wlord_d;
  logic [IW-1:0]    cur_line_q, cur_line_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [IW:0]      nxt_s;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    win_d      = win_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    wlord_d    = '0;
    cur_line_d = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    nxt_s      = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mask_d = bus.mask;
          win_d  = bus.win_len;
          mode_d = bus.mode;
          busy_d = 1'b1;
          if ((bus.mask == '0) || (bus.win_len == '0)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            nxt_s   = next_set(bus.mask, 0);
            line_d  = nxt_s[IW-1:0];
            cnt_d   = bus.win_len - WIDTH'(1);
            state_d = ACTIVE;
            if (bus.mode) begin
              wlord_d    = onehot(nxt_s[IW-1:0]);
              cur_line_d = nxt_s[IW-1:0];
            end else begin
              wlord_d = bus.mask;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        busy_d = 1'b1;
        if (bus.abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = GAP;
        end else begin
          cnt_d      = cnt_q - WIDTH'(1);
          wlord_d    = wlord_q;
          cur_line_d = cur_line_q;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        // The last line's gap can still be aborted; the abort flag wins over normal completion.
        if (bus.abort) begin
          state_d   = DONE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (mode_q) begin
          nxt_s = next_set(mask_q, int'(line_q) + 1);
          if (nxt_s[IW]) begin
            line_d     = nxt_s[IW-1:0];
            cnt_d      = win_q - WIDTH'(1);
            wlord_d    = onehot(nxt_s[IW-1:0]);
            cur_line_d = nxt_s[IW-1:0];
            state_d    = ACTIVE;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mask_q     <= '0;
      win_q      <= '0;
      mode_q     <= 1'b0;
      cnt_q      <= '0;
      line_q     <= '0;
      wlord_q    <= '0;
      cur_line_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      win_q      <= win_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      wlord_q    <= wlord_d;
      cur_line_q <= cur_line_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign bus.wlord    = wlord_q;
  assign bus.cur_line = cur_line_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;

endmodule

// File: tb/tb_wlord_driver.sv
// Directed bench for wlord_driver: a table of sequences checked cycle by cycle
// against an expected enable trace, plus hand-written reset and idle-abort cases.
module tb_wlord_driver;
  localparam int N  = 32;
  localparam int W  = 12;
  localparam int IW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wlord_driver_if #(.N(N), .WIDTH(W), .IW(IW)) bus ();
  wlord_driver #(.N(N), .WIDTH(W), .IW(IW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic         mode;
    logic [N-1:0] mask;
    logic [W-1:0] win;
    int           abort_at;      // -1 none, 0 together with start, >0 cycle index
    bit           start_in_done;
    int           exp_done;      // hand-computed cycle of the done pulse
    bit           exp_ab;
  } vec_t;

  vec_t         vecs[9];
  bit [N-1:0]   exp_w[$];
  int           exp_cl[$];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    int         L, D, first_done;
    bit         ab;
    bit [N-1:0] oh, w;
    int         cl;
    logic       dn, abx;
    exp_w.delete();
    exp_cl.delete();
    if (v.mask != '0 && v.win != '0) begin
      if (!v.mode) begin
        for (int k = 0; k < int'(v.win); k++) begin
          exp_w.push_back(v.mask);
          exp_cl.push_back(0);
        end
        exp_w.push_back('0);
        exp_cl.push_back(0);
      end else begin
        for (int i = 0; i < N; i++) begin
          if (v.mask[i]) begin
            oh = '0;
            oh[i] = 1'b1;
            for (int k = 0; k < int'(v.win); k++) begin
              exp_w.push_back(oh);
              exp_cl.push_back(i);
            end
            exp_w.push_back('0);
            exp_cl.push_back(0);
          end
        end
      end
    end
    L  = exp_w.size();
    D  = L + 1;
    ab = 1'b0;
    if (v.abort_at >= 1 && v.abort_at <= L) begin
      D  = v.abort_at + 1;
      ab = 1'b1;
    end
    bus.start   = 1'b1;
    bus.abort   = (v.abort_at == 0);
    bus.mode    = v.mode;
    bus.mask    = v.mask;
    bus.win_len = v.win;
    @(negedge clk);
    chk($sformatf("v%0d c0 busy", idx), 64'(bus.busy), 64'd0);
    chk($sformatf("v%0d c0 done", idx), 64'(bus.done), 64'd0);
    first_done = 0;
    for (int c = 1; c <= D; c++) begin
      @(posedge clk);
      #1;
      bus.start   = (c == 2 && c < D) || (v.start_in_done && c == D);
      bus.abort   = (c == v.abort_at);
      bus.mode    = ~v.mode;
      bus.mask    = ~v.mask ^ 32'h0000_0001;
      bus.win_len = v.win + 12'd3;
      @(negedge clk);
      if (bus.done === 1'b1 && first_done == 0) first_done = c;
      if (c < D) begin
        w = exp_w[c-1]; cl = exp_cl[c-1]; dn = 1'b0; abx = 1'b0;
      end else begin
        w = '0; cl = 0; dn = 1'b1; abx = ab;
      end
      chk($sformatf("v%0d c%0d wlord", idx, c), 64'(bus.wlord), 64'(w));
      chk($sformatf("v%0d c%0d cur_line", idx, c), 64'(bus.cur_line), 64'(cl));
      chk($sformatf("v%0d c%0d busy", idx, c), 64'(bus.busy), 64'd1);
      chk($sformatf("v%0d c%0d done", idx, c), 64'(bus.done), 64'(dn));
      chk($sformatf("v%0d c%0d aborted", idx, c), 64'(bus.aborted), 64'(abx));
      chk($sformatf("v%0d c%0d in_mask", idx, c), 64'(bus.wlord & ~v.mask), 64'd0);
      if (v.mode) chk($sformatf("v%0d c%0d onehot", idx, c), 64'($countones(bus.wlord) > 1), 64'd0);
    end
    chk($sformatf("v%0d done_cycle", idx), 64'(first_done), 64'(v.exp_done));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h0000_00F0, 12'd5,    -1, 1'b1, 7,    1'b0};
    vecs[1] = '{1'b1, 32'h8000_0005, 12'd3,    -1, 1'b0, 13,   1'b0};
    vecs[2] = '{1'b0, 32'h0000_00FF, 12'd0,    -1, 1'b0, 1,    1'b0};
    vecs[3] = '{1'b1, 32'h0000_0000, 12'd4,    -1, 1'b0, 1,    1'b0};
    vecs[4] = '{1'b1, 32'h0000_00FF, 12'd10,   15, 1'b0, 16,   1'b1};
    vecs[5] = '{1'b0, 32'h0000_0001, 12'd1,    0,  1'b0, 3,    1'b0};
    vecs[6] = '{1'b1, 32'h0000_0003, 12'd1,    -1, 1'b1, 5,    1'b0};
    vecs[7] = '{1'b0, 32'hFFFF_FFFF, 12'd4095, -1, 1'b0, 4097, 1'b0};
    vecs[8] = '{1'b0, 32'h0000_000A, 12'd2,    3,  1'b0, 4,    1'b1};

    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0; bus.mask = '0; bus.win_len = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset wlord", 64'(bus.wlord), 64'd0);
    chk("reset cur_line", 64'(bus.cur_line), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset aborted", 64'(bus.aborted), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Each sequence starts on the cycle right after the previous done pulse.
    for (int i = 0; i < 9; i++) run(vecs[i], i);

    // Abort while idle must not start anything or raise status.
    bus.abort = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("idle_abort c%0d busy", c), 64'(bus.busy), 64'd0);
      chk($sformatf("idle_abort c%0d done", c), 64'(bus.done), 64'd0);
      chk($sformatf("idle_abort c%0d aborted", c), 64'(bus.aborted), 64'd0);
      @(posedge clk);
      #1;
    end
    bus.abort = 1'b0;

    // Reset mid-window: outputs clear on that edge and no done pulse follows.
    bus.start = 1'b1; bus.mode = 1'b0; bus.mask = 32'h0000_00F0; bus.win_len = 12'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_mid c1 wlord", 64'(bus.wlord), 64'h0000_00F0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid c3 wlord", 64'(bus.wlord), 64'h0000_00F0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid c4 wlord", 64'(bus.wlord), 64'd0);
    chk("rst_mid c4 busy", 64'(bus.busy), 64'd0);
    chk("rst_mid c4 done", 64'(bus.done), 64'd0);
    chk("rst_mid c4 aborted", 64'(bus.aborted), 64'd0);
    for (int c = 5; c < 15; c++) begin
      @(negedge clk);
      chk($sformatf("rst_mid c%0d done", c), 64'(bus.done), 64'd0);
      chk($sformatf("rst_mid c%0d wlord", c), 64'(bus.wlord), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
